// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing chain: default count width,
// 640x480 timing values and the sync polarity encoding.
package vga_timing_pkg;

  localparam int C_DEFAULT = 10;

  // 640x480 @ 60 Hz timing, counts are zero-based indices
  localparam int H_LAST    = 799;
  localparam int V_LAST    = 524;
  localparam int V_S_BLANK = 480;
  localparam int V_S_SYNC  = 490;
  localparam int V_R_SYNC  = 492;
  localparam int V_R_BLANK = 0;

  // Sync polarity: level driven on the pin while sync is active
  localparam logic SYNC_POL_LOW = 1'b0;

endpackage

// File: rtl/threshold_flag.sv
// Set/clear flag register driven by count thresholds. When enabled, a count
// equal to s_thr sets the flag, otherwise a count equal to r_thr clears it;
// set wins when both thresholds are equal. Holds when not enabled.
module threshold_flag #(
  parameter int C = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [C-1:0] cnt,
  input  logic [C-1:0] s_thr,
  input  logic [C-1:0] r_thr,
  input  logic         rst_val,
  output logic         flag
);

  logic flag_q, flag_d;

  // Next flag value: set has priority over clear, hold otherwise
  always_comb begin
    flag_d = flag_q;
    if (en) begin
      if (cnt == s_thr) begin
        flag_d = 1'b1;
      end else if (cnt == r_thr) begin
        flag_d = 1'b0;
      end
    end
  end

  // Flag register with synchronous reset to the caller-chosen value
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= rst_val;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/line_counter.sv
// Vertical stage of the VGA timing chain. Advances the line count each cycle
// the pixel count sits at h_last, wraps at v_last, and produces registered
// blank/sync flags plus one-cycle line_end/frame_end strobes.
// Valid/ready: there is no handshake; the only qualifier is the internal tick
// (h_q == h_last), and every output is a register updated on the clk edge.
module line_counter
  import vga_timing_pkg::*;
#(
  parameter int   C        = C_DEFAULT,
  parameter logic SYNC_POL = SYNC_POL_LOW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [C-1:0] h_q,
  input  logic [C-1:0] h_last,
  input  logic [C-1:0] v_last,
  input  logic [C-1:0] s_blank,
  input  logic [C-1:0] s_sync,
  input  logic [C-1:0] r_sync,
  input  logic [C-1:0] r_blank,
  output logic [C-1:0] q,
  output logic         blank,
  output logic         sync,
  output logic         line_end,
  output logic         frame_end
);

  logic [C-1:0] q_q, q_d;
  logic         line_end_q, frame_end_q;
  logic         tick;
  logic         at_last;
  logic         sync_act;

  // End-of-line detect and next line index; the +1 wraps modulo 2^C so a
  // v_last below the current count simply runs up and rolls over.
  always_comb begin
    tick    = (h_q == h_last);
    at_last = (q_q == v_last);
    q_d     = at_last ? '0 : q_q + C'(1);
  end

  // Line counter and strobes; a held h_q == h_last advances one line per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q         <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      line_end_q  <= tick;
      frame_end_q <= tick & at_last;
      if (tick) begin
        q_q <= q_d;
      end
    end
  end

  // Flags compare against the new line index so they change on the same
  // edge as q and always agree with it.
  threshold_flag #(.C(C)) u_blank (
    .clk     (clk),
    .rst     (rst),
    .en      (tick),
    .cnt     (q_d),
    .s_thr   (s_blank),
    .r_thr   (r_blank),
    .rst_val (1'b0),
    .flag    (blank)
  );

  threshold_flag #(.C(C)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .en      (tick),
    .cnt     (q_d),
    .s_thr   (s_sync),
    .r_thr   (r_sync),
    .rst_val (1'b0),
    .flag    (sync_act)
  );

  // sync_act is registered; mapping it to the pin polarity is a fixed inversion
  assign sync      = sync_act ? SYNC_POL : ~SYNC_POL;
  assign q         = q_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_line_counter.sv
// Bench for line_counter: per-cycle scoreboard against a behavioural model,
// a table of short vectors with hand-derived outputs, and directed sequences
// for line period, full frame, set priority, mid-frame reset and stall.
module tb_line_counter;
  import vga_timing_pkg::*;

  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] q;
    logic         blank;
    logic         sync;
    logic         le;
    logic         fe;
  } out_t;

  typedef struct packed {
    logic         rst;
    logic [W-1:0] h;
    out_t         exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] h_q, h_last, v_last, s_blank, s_sync, r_sync, r_blank;
  logic [W-1:0] q;
  logic         blank, sync, line_end, frame_end;

  always #5 clk = ~clk;

  line_counter #(.C(W), .SYNC_POL(SYNC_POL_LOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .h_q       (h_q),
    .h_last    (h_last),
    .v_last    (v_last),
    .s_blank   (s_blank),
    .s_sync    (s_sync),
    .r_sync    (r_sync),
    .r_blank   (r_blank),
    .q         (q),
    .blank     (blank),
    .sync      (sync),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // ---------------- scoreboard state ----------------
  out_t exp_q[$];
  out_t act;
  int   n_pass  = 0;
  int   n_total = 0;

  // behavioural model state
  logic [W-1:0] m_q;
  logic         m_blank, m_sync_act, m_le, m_fe;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Model one edge from the spec's description of line_counter
  task automatic model_step(input logic r, input logic [W-1:0] h);
    logic [W-1:0] nq;
    if (r) begin
      m_q = '0; m_blank = 1'b0; m_sync_act = 1'b0; m_le = 1'b0; m_fe = 1'b0;
    end else if (h == h_last) begin
      nq   = (m_q == v_last) ? '0 : W'(m_q + 1);
      m_fe = (m_q == v_last);
      m_le = 1'b1;
      if (nq == s_blank)      m_blank = 1'b1;
      else if (nq == r_blank) m_blank = 1'b0;
      if (nq == s_sync)       m_sync_act = 1'b1;
      else if (nq == r_sync)  m_sync_act = 1'b0;
      m_q = nq;
    end else begin
      m_le = 1'b0;
      m_fe = 1'b0;
    end
  endtask

  // Driver: apply inputs for one cycle, push expectation, compare after edge
  task automatic drive_cycle(input logic r, input logic [W-1:0] h);
    out_t e, got;
    rst = r;
    h_q = h;
    model_step(r, h);
    e.q = m_q; e.blank = m_blank; e.sync = m_sync_act ? SYNC_POL_LOW : ~SYNC_POL_LOW;
    e.le = m_le; e.fe = m_fe;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.q = q; got.blank = blank; got.sync = sync; got.le = line_end; got.fe = frame_end;
    act = got;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      check("sb_model", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic set_vga_cfg();
    h_last  = W'(H_LAST);
    v_last  = W'(V_LAST);
    s_blank = W'(V_S_BLANK);
    r_blank = W'(V_R_BLANK);
    s_sync  = W'(V_S_SYNC);
    r_sync  = W'(V_R_SYNC);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[12];
    int   pulses, fe_pulses;
    logic [W-1:0] base;

    // small config: h_last=2, v_last=3, blank 2..0, sync set 3 clear 1
    //               rst   h         q      b     s     le    fe
    vecs[0]  = '{1'b1, 10'd0, '{10'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{1'b0, 10'd0, '{10'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{1'b0, 10'd2, '{10'd1, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[3]  = '{1'b0, 10'd2, '{10'd2, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[4]  = '{1'b0, 10'd0, '{10'd2, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{1'b0, 10'd2, '{10'd3, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{1'b0, 10'd1, '{10'd3, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{1'b0, 10'd2, '{10'd0, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[8]  = '{1'b0, 10'd2, '{10'd1, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[9]  = '{1'b0, 10'd2, '{10'd2, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[10] = '{1'b1, 10'd2, '{10'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{1'b0, 10'd2, '{10'd1, 1'b0, 1'b1, 1'b1, 1'b0}};

    rst = 1'b1;
    h_q = '0;
    set_vga_cfg();
    #1;

    // reset with 640x480 constants, 3 cycles
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'($urandom_range(0, 799)));
    check("reset_state", 32'(act), 32'(out_t'{10'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // table vectors on the small config
    h_last = 10'd2; v_last = 10'd3; s_blank = 10'd2; r_blank = 10'd0;
    s_sync = 10'd3; r_sync = 10'd1;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].h);
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end

    // line period: h_q 0..799 three times
    set_vga_cfg();
    drive_cycle(1'b1, 10'd0);
    pulses = 0;
    for (int line = 0; line < 3; line++) begin
      for (int h = 0; h < 800; h++) begin
        drive_cycle(1'b0, W'(h));
        if (act.le) pulses++;
        if (h == 798) check("line_hold", 32'(act.q), 32'(line));
        if (h == 799) check("line_step", 32'({act.q, act.le}), 32'({W'(line + 1), 1'b1}));
      end
    end
    check("line_pulses", 32'(pulses), 32'd3);

    // full frame, short lines (h_last=1) to keep run time small
    h_last = 10'd1;
    drive_cycle(1'b1, 10'd0);
    fe_pulses = 0;
    for (int line = 0; line < 525; line++) begin
      drive_cycle(1'b0, 10'd0);
      if (act.fe) fe_pulses++;
      drive_cycle(1'b0, 10'd1);
      if (act.fe) fe_pulses++;
      base = W'((line + 1) % 525);
      check("frame_flags", 32'({act.q, act.blank, act.sync, act.fe}),
            32'({base, base >= 10'd480, !(base >= 10'd490 && base < 10'd492), line == 524}));
    end
    check("frame_end_once", 32'(fe_pulses), 32'd1);

    // set priority on sync, blank threshold beyond v_last; one line per cycle
    set_vga_cfg();
    s_sync = 10'd5; r_sync = 10'd5; s_blank = 10'd600;
    drive_cycle(1'b1, 10'd0);
    for (int i = 0; i < 1050; i++) begin
      drive_cycle(1'b0, 10'd799);
      check("prio_flags", 32'({act.q, act.blank, act.sync}),
            32'({W'((i + 1) % 525), 1'b0, (i + 1) < 5}));
    end

    // reset at line 300, then line 1 appears 800 clocks after release
    set_vga_cfg();
    drive_cycle(1'b1, 10'd0);
    for (int i = 0; i < 300; i++) drive_cycle(1'b0, 10'd799);
    check("pre_rst_q300", 32'({act.q, act.blank}), 32'({10'd300, 1'b0}));
    drive_cycle(1'b1, 10'd799);
    check("mid_rst", 32'(act), 32'(out_t'{10'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    for (int h = 0; h < 800; h++) begin
      drive_cycle(1'b0, W'(h));
      if (h == 798) check("post_rst_hold", 32'(act.q), 32'd0);
      if (h == 799) check("post_rst_line1", 32'({act.q, act.le}), 32'({10'd1, 1'b1}));
    end

    // stall: h_q held at h_last for 4 cycles
    drive_cycle(1'b0, 10'd0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 10'd799);
      check("stall_step", 32'({act.q, act.le}), 32'({W'(2 + i), 1'b1}));
    end
    drive_cycle(1'b0, 10'd0);
    check("stall_release", 32'({act.q, act.le}), 32'({10'd5, 1'b0}));

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
